// File: rtl/rx_deframer_if.sv
// Bit-stream input and frame-event output bundle for rx_deframer.
// master = decoder/host side driving the bit stream, slave = the deframer.
interface rx_deframer_if;
    logic       rx_ce;
    logic       rx_sdata;
    logic       rx_sync;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_start;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_ce, rx_sdata, rx_sync,
        input  data, data_valid, frame_start, frame_len, frame_ok, frame_err, err_code, busy
    );

    modport slave (
        input  rx_ce, rx_sdata, rx_sync,
        output data, data_valid, frame_start, frame_len, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/rx_deframer.sv
// Serial frame deframer: hunts for SYNC_WORD, then parses LEN, payload and an
// additive 8-bit checksum, emitting 1-cycle event strobes one clock after the completing bit.
module rx_deframer #(
    parameter logic [15:0] SYNC_WORD = 16'h7E81,
    parameter logic [7:0]  MAX_LEN   = 8'd64
) (
    input logic          clk_i,
    input logic          rst_ni,
    rx_deframer_if.slave bus
);
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK} state_e;

    state_e      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  frame_len_q, frame_len_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] sr_shift;
    logic [7:0]  rx_byte;

    // Outside HUNT the low byte of the shift register doubles as the byte assembler.
    assign sr_shift = {sr_q[14:0], bus.rx_sdata};
    assign rx_byte  = sr_shift[7:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            sum_q         <= '0;
            data_q        <= '0;
            frame_len_q   <= '0;
            err_code_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            sum_q         <= sum_d;
            data_q        <= data_d;
            frame_len_q   <= frame_len_d;
            err_code_q    <= err_code_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        sum_d         = sum_q;
        data_d        = data_q;
        frame_len_d   = frame_len_q;
        err_code_d    = err_code_q;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;

        if (state_q == S_HUNT) begin
            if (!bus.rx_sync) begin
                sr_d = '0;
            end else if (bus.rx_ce) begin
                sr_d = sr_shift;
                if (sr_shift == SYNC_WORD) begin
                    frame_start_d = 1'b1;
                    bit_cnt_d     = '0;
                    sum_d         = '0;
                    state_d       = S_LEN;
                end
            end
        end else if (!bus.rx_sync) begin
            // Sync loss outranks any bit strobed in the same cycle.
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            sr_d        = '0;
            bit_cnt_d   = '0;
            state_d     = S_HUNT;
        end else if (bus.rx_ce) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    S_LEN: begin
                        if (rx_byte > MAX_LEN) begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd2;
                            sr_d        = '0;
                            state_d     = S_HUNT;
                        end else begin
                            frame_len_d = rx_byte;
                            sum_d       = rx_byte;
                            byte_cnt_d  = rx_byte;
                            state_d     = (rx_byte == 8'd0) ? S_CHECK : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        data_d       = rx_byte;
                        data_valid_d = 1'b1;
                        sum_d        = sum_q + rx_byte;
                        byte_cnt_d   = byte_cnt_q - 8'd1;
                        if (byte_cnt_q == 8'd1) state_d = S_CHECK;
                    end
                    S_CHECK: begin
                        if (rx_byte == sum_q) begin
                            frame_ok_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd1;
                        end
                        sr_d    = '0;
                        state_d = S_HUNT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_code    = err_code_q;
    assign bus.busy        = (state_q != S_HUNT);
endmodule
